// File: rtl/mod_symbol_mapper.sv
// rtl/mod_symbol_mapper.sv - BPSK/QPSK/16-QAM constellation mapper with valid/ready handshakes
module mod_symbol_mapper #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 4,
  parameter int PSK_AMP = 2,
  parameter int QAM_U   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    sym_last,
  output logic                    busy,
  output logic                    mode_err
);

  // Parameter sanity checks at elaboration time
  if (IN_W % 4 != 0) begin : g_bad_in_w
    $error("mod_symbol_mapper: IN_W must be a multiple of 4");
  end
  if (PSK_AMP > (2 ** (OUT_W - 1)) - 1) begin : g_bad_psk_amp
    $error("mod_symbol_mapper: PSK_AMP does not fit in OUT_W signed");
  end
  if (3 * QAM_U > (2 ** (OUT_W - 1)) - 1) begin : g_bad_qam_u
    $error("mod_symbol_mapper: 3*QAM_U does not fit in OUT_W signed");
  end

  localparam int RW = $clog2(IN_W + 1);

  localparam logic signed [OUT_W-1:0] PSK_POS = OUT_W'(PSK_AMP);
  localparam logic signed [OUT_W-1:0] PSK_NEG = OUT_W'(-PSK_AMP);
  localparam logic signed [OUT_W-1:0] QAM_P1  = OUT_W'(QAM_U);
  localparam logic signed [OUT_W-1:0] QAM_N1  = OUT_W'(-QAM_U);
  localparam logic signed [OUT_W-1:0] QAM_P3  = OUT_W'(3 * QAM_U);
  localparam logic signed [OUT_W-1:0] QAM_N3  = OUT_W'(-3 * QAM_U);

  localparam logic [1:0] MODE_BPSK = 2'b00;
  localparam logic [1:0] MODE_QPSK = 2'b01;
  localparam logic [1:0] MODE_QAM  = 2'b10;
  localparam logic [1:0] MODE_RSV  = 2'b11;

  // Gray-coded 16-QAM axis level for one bit pair
  function automatic logic signed [OUT_W-1:0] qam_lvl(input logic [1:0] b);
    logic signed [OUT_W-1:0] v;
    case (b)
      2'b00:   v = QAM_N3;
      2'b01:   v = QAM_N1;
      2'b11:   v = QAM_P1;
      default: v = QAM_P3;
    endcase
    return v;
  endfunction

  // Map the top four bits of a word window to {I, Q}; only the top bps bits matter
  function automatic logic [2*OUT_W-1:0] map_sym(input logic [1:0] m, input logic [3:0] b);
    logic signed [OUT_W-1:0] i_v;
    logic signed [OUT_W-1:0] q_v;
    i_v = '0;
    q_v = '0;
    case (m)
      MODE_BPSK: i_v = b[3] ? PSK_NEG : PSK_POS;
      MODE_QPSK: begin
        // bits {b1,b0} = b[3:2]; I sign follows b0, Q sign follows b1
        i_v = b[2] ? PSK_NEG : PSK_POS;
        q_v = b[3] ? PSK_NEG : PSK_POS;
      end
      MODE_QAM: begin
        i_v = qam_lvl(b[3:2]);
        q_v = qam_lvl(b[1:0]);
      end
      default: ;
    endcase
    return {i_v, q_v};
  endfunction

  // Symbols per word for a mode
  function automatic logic [RW-1:0] spw_of(input logic [1:0] m);
    logic [RW-1:0] v;
    case (m)
      MODE_BPSK: v = RW'(IN_W);
      MODE_QPSK: v = RW'(IN_W / 2);
      default:   v = RW'(IN_W / 4);
    endcase
    return v;
  endfunction

  // Drop the bits of the symbol just consumed
  function automatic logic [IN_W-1:0] shift_of(input logic [1:0] m, input logic [IN_W-1:0] v);
    logic [IN_W-1:0] r;
    case (m)
      MODE_BPSK: r = v << 1;
      MODE_QPSK: r = v << 2;
      default:   r = v << 4;
    endcase
    return r;
  endfunction

  logic [1:0]              mode_q, mode_d;
  logic [IN_W-1:0]         shift_q, shift_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] i_q, i_d;
  logic signed [OUT_W-1:0] q_q, q_d;
  logic                    sym_last_q, sym_last_d;
  logic                    mode_err_q, mode_err_d;

  logic                    free;
  logic                    accept;
  logic [2*OUT_W-1:0]      sym_new;
  logic [2*OUT_W-1:0]      sym_nxt;
  logic [RW-1:0]           spw_new;

  assign free     = !out_valid_q || out_ready;
  assign in_ready = (rem_q == '0) && free;
  assign accept   = in_valid && in_ready;
  assign sym_new  = map_sym(mode, in_data[IN_W-1 -: 4]);
  assign sym_nxt  = map_sym(mode_q, shift_q[IN_W-1 -: 4]);
  assign spw_new  = spw_of(mode);

  // Next-state: accept a word, advance the shift register, or drain the output slot
  always_comb begin
    mode_d      = mode_q;
    shift_d     = shift_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    i_d         = i_q;
    q_d         = q_q;
    sym_last_d  = sym_last_q;
    mode_err_d  = 1'b0;
    if (accept) begin
      mode_d = mode;
      if (mode == MODE_RSV) begin
        // reserved mode: word is swallowed, output slot simply empties
        mode_err_d  = 1'b1;
        out_valid_d = 1'b0;
        sym_last_d  = 1'b0;
        rem_d       = '0;
      end else begin
        out_valid_d = 1'b1;
        i_d         = sym_new[2*OUT_W-1:OUT_W];
        q_d         = sym_new[OUT_W-1:0];
        shift_d     = shift_of(mode, in_data);
        rem_d       = spw_new - RW'(1);
        sym_last_d  = (spw_new == RW'(1));
      end
    end else if (rem_q != '0 && free) begin
      out_valid_d = 1'b1;
      i_d         = sym_nxt[2*OUT_W-1:OUT_W];
      q_d         = sym_nxt[OUT_W-1:0];
      shift_d     = shift_of(mode_q, shift_q);
      rem_d       = rem_q - RW'(1);
      sym_last_d  = (rem_q == RW'(1));
    end else if (free) begin
      // nothing to load: I/Q keep their last value
      out_valid_d = 1'b0;
      sym_last_d  = 1'b0;
    end
  end

  // State registers with asynchronous reset that drops any pending symbols
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 2'b00;
      shift_q     <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      i_q         <= '0;
      q_q         <= '0;
      sym_last_q  <= 1'b0;
      mode_err_q  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      shift_q     <= shift_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      i_q         <= i_d;
      q_q         <= q_d;
      sym_last_q  <= sym_last_d;
      mode_err_q  <= mode_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign i_out     = i_q;
  assign q_out     = q_q;
  assign sym_last  = sym_last_q;
  assign mode_err  = mode_err_q;
  assign busy      = (rem_q != '0) || out_valid_q;

endmodule

// File: tb/tb_mod_symbol_mapper.sv
// tb/tb_mod_symbol_mapper.sv - directed self-checking bench for mod_symbol_mapper
module tb_mod_symbol_mapper;

  logic              clk;
  logic              rst_n;
  logic [1:0]        mode;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [3:0] i_out;
  logic signed [3:0] q_out;
  logic              sym_last;
  logic              busy;
  logic              mode_err;

  int total;
  int bad;

  mod_symbol_mapper #(.IN_W(8), .OUT_W(4), .PSK_AMP(2), .QAM_U(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .i_out    (i_out),
    .q_out    (q_out),
    .sym_last (sym_last),
    .busy     (busy),
    .mode_err (mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset: all outputs at their reset values, mapper ready
  task automatic test_reset();
    rst_n = 1'b0; mode = 2'b00; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, i_out, q_out, sym_last, mode_err, busy} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b i=%0d q=%0d last=%b err=%b busy=%b want all 0",
               out_valid, i_out, q_out, sym_last, mode_err, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  // QPSK 00_01_11_10: Gray map, sym_last only on the 4th, I/Q hold after drain
  task automatic test_qpsk();
    logic signed [3:0] ei [4] = '{4'sd2, -4'sd2, -4'sd2, 4'sd2};
    logic signed [3:0] eq [4] = '{4'sd2, 4'sd2, -4'sd2, -4'sd2};
    mode = 2'b01; in_data = 8'h1E; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if ({out_valid, i_out, q_out, sym_last} !== {1'b1, ei[k], eq[k], k == 3}) begin
        bad++;
        $display("FAIL qpsk_sym%0d: got v=%b i=%0d q=%0d last=%b want v=1 i=%0d q=%0d last=%b",
                 k, out_valid, i_out, q_out, sym_last, ei[k], eq[k], k == 3);
      end
    end
    @(negedge clk);
    total++;
    if ({out_valid, i_out, q_out, sym_last, busy} !== {1'b0, 4'sd2, -4'sd2, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL qpsk_drain: got v=%b i=%0d q=%0d last=%b busy=%b want v=0 i=2 q=-2 last=0 busy=0",
               out_valid, i_out, q_out, sym_last, busy);
    end
  endtask

  // BPSK 0xA5: eight symbols, in_ready low for 7 cycles after accept
  task automatic test_bpsk();
    logic [7:0] w;
    logic signed [3:0] ei;
    w = 8'hA5;
    mode = 2'b00; in_data = w; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      ei = w[7-k] ? -4'sd2 : 4'sd2;
      total++;
      if ({out_valid, i_out, q_out, sym_last, in_ready} !== {1'b1, ei, 4'sd0, k == 7, k == 7}) begin
        bad++;
        $display("FAIL bpsk_sym%0d: got v=%b i=%0d q=%0d last=%b rdy=%b want v=1 i=%0d q=0 last=%b rdy=%b",
                 k, out_valid, i_out, q_out, sym_last, in_ready, ei, k == 7, k == 7);
      end
    end
    @(negedge clk);
  endtask

  // 16-QAM 0x3C: (-3,+1) then (+1,-3)
  task automatic test_qam();
    logic signed [3:0] ei [2] = '{-4'sd3, 4'sd1};
    logic signed [3:0] eq [2] = '{4'sd1, -4'sd3};
    mode = 2'b10; in_data = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if ({out_valid, i_out, q_out, sym_last} !== {1'b1, ei[k], eq[k], k == 1}) begin
        bad++;
        $display("FAIL qam_sym%0d: got v=%b i=%0d q=%0d last=%b want v=1 i=%0d q=%0d last=%b",
                 k, out_valid, i_out, q_out, sym_last, ei[k], eq[k], k == 1);
      end
    end
    @(negedge clk);
  endtask

  // Two QPSK words with in_valid held: eight symbols with no bubble
  task automatic test_back_to_back();
    logic signed [3:0] ei [8] = '{4'sd2, -4'sd2, -4'sd2, 4'sd2, 4'sd2, -4'sd2, -4'sd2, 4'sd2};
    logic signed [3:0] eq [8] = '{4'sd2, 4'sd2, -4'sd2, -4'sd2, -4'sd2, -4'sd2, 4'sd2, 4'sd2};
    mode = 2'b01; in_data = 8'h1E; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) in_data = 8'hB4;
      if (k == 4) in_valid = 1'b0;
      total++;
      if ({out_valid, i_out, q_out, sym_last} !== {1'b1, ei[k], eq[k], (k == 3) || (k == 7)}) begin
        bad++;
        $display("FAIL b2b_sym%0d: got v=%b i=%0d q=%0d last=%b want v=1 i=%0d q=%0d last=%b",
                 k, out_valid, i_out, q_out, sym_last, ei[k], eq[k], (k == 3) || (k == 7));
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Output stall for 3 cycles after the first symbol, then remaining symbols in order
  task automatic test_backpressure();
    logic signed [3:0] ei [3] = '{-4'sd2, -4'sd2, 4'sd2};
    logic signed [3:0] eq [3] = '{4'sd2, -4'sd2, -4'sd2};
    mode = 2'b01; in_data = 8'h1E; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({out_valid, i_out, q_out, sym_last, in_ready, busy} !== {1'b1, 4'sd2, 4'sd2, 1'b0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL stall_hold%0d: got v=%b i=%0d q=%0d last=%b rdy=%b busy=%b want v=1 i=2 q=2 last=0 rdy=0 busy=1",
                 k, out_valid, i_out, q_out, sym_last, in_ready, busy);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({out_valid, i_out, q_out, sym_last} !== {1'b1, ei[k], eq[k], k == 2}) begin
        bad++;
        $display("FAIL stall_sym%0d: got v=%b i=%0d q=%0d last=%b want v=1 i=%0d q=%0d last=%b",
                 k, out_valid, i_out, q_out, sym_last, ei[k], eq[k], k == 2);
      end
    end
    @(negedge clk);
  endtask

  // Reserved mode: one-cycle mode_err pulse, no symbols
  task automatic test_mode_err();
    mode = 2'b11; in_data = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({mode_err, out_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL mode_err_pulse: got err=%b v=%b busy=%b want err=1 v=0 busy=0", mode_err, out_valid, busy);
    end
    @(negedge clk);
    total++;
    if ({mode_err, out_valid, in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL mode_err_clear: got err=%b v=%b rdy=%b want err=0 v=0 rdy=1", mode_err, out_valid, in_ready);
    end
  endtask

  // Asynchronous reset in the middle of a BPSK word drops everything
  task automatic test_reset_mid_word();
    mode = 2'b00; in_data = 8'h5A; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, busy} !== 2'b11) begin
      bad++;
      $display("FAIL mid_word_active: got v=%b busy=%b want v=1 busy=1", out_valid, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, i_out, q_out, sym_last, mode_err, busy} !== 13'h0) begin
      bad++;
      $display("FAIL mid_word_reset: got v=%b i=%0d q=%0d last=%b err=%b busy=%b want all 0",
               out_valid, i_out, q_out, sym_last, mode_err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, i_out, q_out, busy, in_ready} !== {1'b0, 4'sd0, 4'sd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mid_word_release: got v=%b i=%0d q=%0d busy=%b rdy=%b want v=0 i=0 q=0 busy=0 rdy=1",
               out_valid, i_out, q_out, busy, in_ready);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_qpsk();
    test_bpsk();
    test_qam();
    test_back_to_back();
    test_backpressure();
    test_mode_err();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
